// File: rtl/serial_mod_n_if.sv
// Bit-stream port bundle for serial_mod_n: framed input beats plus remainder/verdict outputs.
interface serial_mod_n_if #(
  parameter int unsigned MOD = 3
);
  localparam int unsigned RW = $clog2(MOD);

  logic          din_vld;
  logic          din;
  logic          sof;
  logic          eof;
  logic [RW-1:0] rem;
  logic          div;
  logic          frm_done;
  logic          frm_div;
  logic [RW-1:0] frm_rem;
  logic          err;

  modport master (
    output din_vld, din, sof, eof,
    input  rem, div, frm_done, frm_div, frm_rem, err
  );

  modport slave (
    input  din_vld, din, sof, eof,
    output rem, div, frm_done, frm_div, frm_rem, err
  );
endinterface

// File: rtl/serial_mod_n.sv
// Serial divisibility checker: running remainder modulo MOD of a framed bitstream, with frame verdicts.
// Define SERIAL_MOD_LSB_FIRST_EN for LSB-first bit order (adds a weight register); default is MSB-first.
module serial_mod_n #(
  parameter int unsigned MOD      = 3,
  parameter int unsigned MAX_BITS = 64
) (
  input logic          clk,
  input logic          rst,
  serial_mod_n_if.slave bus
);
  localparam int unsigned RW = $clog2(MOD);
  // Counter must hold the saturation value MAX_BITS+1
  localparam int unsigned CW = $clog2(MAX_BITS + 2);

  localparam logic [RW:0]   MOD_W   = (RW+1)'(MOD);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BITS);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_BITS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] rem_q;
  logic          div_q;
  logic          frm_done_q;
  logic          frm_div_q;
  logic [RW-1:0] frm_rem_q;
  logic          err_q;

  logic          accept;
  logic [RW-1:0] r_base;
  logic [RW:0]   r_sum;
  logic [RW-1:0] r_nxt;

`ifdef SERIAL_MOD_LSB_FIRST_EN
  logic [RW-1:0] w_q;
  logic [RW-1:0] w_base;
  logic [RW:0]   w_sum;
  logic [RW-1:0] w_nxt;
`endif

  // Next remainder for the current beat; a sof beat restarts from zero
  always_comb begin
    accept = bus.din_vld && (bus.sof || (state == RUN));
    r_base = bus.sof ? '0 : rem_q;
`ifdef SERIAL_MOD_LSB_FIRST_EN
    w_base = bus.sof ? RW'(1) : w_q;
    r_sum  = (RW+1)'(r_base) + (bus.din ? (RW+1)'(w_base) : '0);
    w_sum  = {w_base, 1'b0};
    w_nxt  = (w_sum >= MOD_W) ? RW'(w_sum - MOD_W) : RW'(w_sum);
`else
    r_sum  = {r_base, bus.din};
`endif
    r_nxt  = (r_sum >= MOD_W) ? RW'(r_sum - MOD_W) : RW'(r_sum);
  end

  // Frame FSM with all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      div_q      <= 1'b0;
      frm_done_q <= 1'b0;
      frm_div_q  <= 1'b0;
      frm_rem_q  <= '0;
      err_q      <= 1'b0;
`ifdef SERIAL_MOD_LSB_FIRST_EN
      w_q        <= '0;
`endif
    end else begin
      frm_done_q <= 1'b0;
      if (accept) begin
        rem_q <= r_nxt;
        div_q <= (r_nxt == '0);
`ifdef SERIAL_MOD_LSB_FIRST_EN
        w_q   <= w_nxt;
`endif
        if (bus.sof) begin
          cnt_q <= CW'(1);
          err_q <= 1'b0;
        end else begin
          if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_MAX) err_q <= 1'b1;
        end
        if (bus.eof) begin
          state      <= IDLE;
          frm_done_q <= 1'b1;
          frm_rem_q  <= r_nxt;
          frm_div_q  <= (r_nxt == '0);
        end else begin
          state <= RUN;
        end
      end
    end
  end

  assign bus.rem      = rem_q;
  assign bus.div      = div_q;
  assign bus.frm_done = frm_done_q;
  assign bus.frm_div  = frm_div_q;
  assign bus.frm_rem  = frm_rem_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_serial_mod_n.sv
// Self-checking bench for serial_mod_n: three DUT configurations share one stimulus stream,
// checked against an arithmetic frame model, directed vector tables and corner sequences.
module tb_serial_mod_n;
  logic clk = 1'b0;
  logic rst;
  logic v, d, s, e;

  always #5 clk = ~clk;

  serial_mod_n_if #(.MOD(3))  if_a ();
  serial_mod_n_if #(.MOD(5))  if_b ();
  serial_mod_n_if #(.MOD(11)) if_c ();

  assign if_a.din_vld = v; assign if_a.din = d; assign if_a.sof = s; assign if_a.eof = e;
  assign if_b.din_vld = v; assign if_b.din = d; assign if_b.sof = s; assign if_b.eof = e;
  assign if_c.din_vld = v; assign if_c.din = d; assign if_c.sof = s; assign if_c.eof = e;

  serial_mod_n #(.MOD(3),  .MAX_BITS(64)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  serial_mod_n #(.MOD(5),  .MAX_BITS(64)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  serial_mod_n #(.MOD(11), .MAX_BITS(8))  u_c (.clk(clk), .rst(rst), .bus(if_c));

  int    total = 0;
  int    bad   = 0;
  int    mods[3] = '{3, 5, 11};
  int    maxb[3] = '{64, 64, 8};
  string nm[3]   = '{"a", "b", "c"};

  // Frame-level reference: remainder of the received prefix value, plus bit count
  int m_rem[3], m_len[3], m_frem[3];
  bit m_run[3], m_div[3], m_done[3], m_fdiv[3], m_err[3];

  typedef struct { int rem; int div; int done; int frem; int fdiv; int err; } obs_t;

  typedef struct {
    int k; bit v; bit d; bit s; bit e;
    int rem; int div; int done; int frem; int fdiv; int err;
  } vec_t;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_rem[k] = 0; m_len[k] = 0; m_frem[k] = 0;
      m_run[k] = 0; m_div[k] = 0; m_done[k] = 0; m_fdiv[k] = 0; m_err[k] = 0;
    end
  endfunction

  function automatic void model_step(int k, bit vv, bit dd, bit ss, bit ee);
`ifdef SERIAL_MOD_LSB_FIRST_EN
    int w;
`endif
    m_done[k] = 0;
    if (!(vv && (ss || m_run[k]))) return;
    if (ss) begin
      m_rem[k] = 0;
      m_len[k] = 0;
    end
`ifdef SERIAL_MOD_LSB_FIRST_EN
    w = 1;
    for (int i = 0; i < m_len[k]; i++) w = (w * 2) % mods[k];
    m_rem[k] = (m_rem[k] + (dd ? w : 0)) % mods[k];
`else
    m_rem[k] = (m_rem[k] * 2 + int'(dd)) % mods[k];
`endif
    m_len[k]++;
    m_err[k] = (m_len[k] > maxb[k]);
    m_div[k] = (m_rem[k] == 0);
    if (ee) begin
      m_done[k] = 1;
      m_frem[k] = m_rem[k];
      m_fdiv[k] = m_div[k];
      m_run[k]  = 0;
    end else begin
      m_run[k] = 1;
    end
  endfunction

  function automatic obs_t observe(int k);
    obs_t o;
    if (k == 0) begin
      o.rem = int'(if_a.rem); o.div = int'(if_a.div); o.done = int'(if_a.frm_done);
      o.frem = int'(if_a.frm_rem); o.fdiv = int'(if_a.frm_div); o.err = int'(if_a.err);
    end else if (k == 1) begin
      o.rem = int'(if_b.rem); o.div = int'(if_b.div); o.done = int'(if_b.frm_done);
      o.frem = int'(if_b.frm_rem); o.fdiv = int'(if_b.frm_div); o.err = int'(if_b.err);
    end else begin
      o.rem = int'(if_c.rem); o.div = int'(if_c.div); o.done = int'(if_c.frm_done);
      o.frem = int'(if_c.frm_rem); o.fdiv = int'(if_c.frm_div); o.err = int'(if_c.err);
    end
    return o;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    obs_t o;
    for (int k = 0; k < 3; k++) begin
      o = observe(k);
      cmp({nm[k], ".rem"},      o.rem,  m_rem[k]);
      cmp({nm[k], ".div"},      o.div,  int'(m_div[k]));
      cmp({nm[k], ".frm_done"}, o.done, int'(m_done[k]));
      cmp({nm[k], ".frm_rem"},  o.frem, m_frem[k]);
      cmp({nm[k], ".frm_div"},  o.fdiv, int'(m_fdiv[k]));
      cmp({nm[k], ".err"},      o.err,  int'(m_err[k]));
    end
  endtask

  task automatic beat(input bit vv, input bit dd, input bit ss, input bit ee);
    @(negedge clk);
    v = vv; d = dd; s = ss; e = ee;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, vv, dd, ss, ee);
    #1 check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    v = 1'b0; s = 1'b0; e = 1'b0;
    model_reset();
    #2 check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t tbl[$];
  obs_t o;

  initial begin
    rst = 1'b1; v = 1'b0; d = 1'b0; s = 1'b0; e = 1'b0;
    #3 rst = 1'b0;
    model_reset();
    #4 check_all();
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors: {dut, vld, din, sof, eof, rem, div, frm_done, frm_rem, frm_div, err}
`ifdef SERIAL_MOD_LSB_FIRST_EN
    // Modulus 5, bits 1,0,-,-,1,1 LSB-first = 13
    tbl.push_back('{1, 1,1,1,0, 1,0,0,0,0,0});
    tbl.push_back('{1, 1,0,0,0, 1,0,0,0,0,0});
    tbl.push_back('{1, 0,0,0,0, 1,0,0,0,0,0});
    tbl.push_back('{1, 0,0,0,0, 1,0,0,0,0,0});
    tbl.push_back('{1, 1,1,0,0, 0,1,0,0,0,0});
    tbl.push_back('{1, 1,1,0,1, 3,0,1,3,0,0});
    // Modulus 3 (saw 13 -> frm_rem 1), then bits 0,1,1 LSB-first = 6
    tbl.push_back('{0, 1,0,1,0, 0,1,0,1,0,0});
    tbl.push_back('{0, 1,1,0,0, 2,0,0,1,0,0});
    tbl.push_back('{0, 1,1,0,1, 0,1,1,0,1,0});
    tbl.push_back('{0, 0,0,0,0, 0,1,0,0,1,0});
    tbl.push_back('{0, 1,1,0,0, 0,1,0,0,1,0});
    tbl.push_back('{0, 1,1,1,0, 1,0,0,0,1,0});
    tbl.push_back('{0, 1,0,0,0, 1,0,0,0,1,0});
    tbl.push_back('{0, 1,1,1,0, 1,0,0,0,1,0});
    tbl.push_back('{0, 1,1,0,1, 0,1,1,0,1,0});
`else
    // Modulus 5, bits 1,0,-,-,1,1 = 11
    tbl.push_back('{1, 1,1,1,0, 1,0,0,0,0,0});
    tbl.push_back('{1, 1,0,0,0, 2,0,0,0,0,0});
    tbl.push_back('{1, 0,0,0,0, 2,0,0,0,0,0});
    tbl.push_back('{1, 0,0,0,0, 2,0,0,0,0,0});
    tbl.push_back('{1, 1,1,0,0, 0,1,0,0,0,0});
    tbl.push_back('{1, 1,1,0,1, 1,0,1,1,0,0});
    // Modulus 3 (saw 11 -> frm_rem 2), then frame 1,1,0 = 6
    tbl.push_back('{0, 1,1,1,0, 1,0,0,2,0,0});
    tbl.push_back('{0, 1,1,0,0, 0,1,0,2,0,0});
    tbl.push_back('{0, 1,0,0,1, 0,1,1,0,1,0});
    tbl.push_back('{0, 0,0,0,0, 0,1,0,0,1,0});
    tbl.push_back('{0, 1,1,0,0, 0,1,0,0,1,0});
    tbl.push_back('{0, 1,1,1,0, 1,0,0,0,1,0});
    tbl.push_back('{0, 1,0,0,0, 2,0,0,0,1,0});
    tbl.push_back('{0, 1,1,1,0, 1,0,0,0,1,0});
    tbl.push_back('{0, 1,1,0,1, 0,1,1,0,1,0});
`endif
    foreach (tbl[i]) begin
      beat(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].e);
      o = observe(tbl[i].k);
      cmp($sformatf("vec%0d.rem", i),      o.rem,  tbl[i].rem);
      cmp($sformatf("vec%0d.div", i),      o.div,  tbl[i].div);
      cmp($sformatf("vec%0d.frm_done", i), o.done, tbl[i].done);
      cmp($sformatf("vec%0d.frm_rem", i),  o.frem, tbl[i].frem);
      cmp($sformatf("vec%0d.frm_div", i),  o.fdiv, tbl[i].fdiv);
      cmp($sformatf("vec%0d.err", i),      o.err,  tbl[i].err);
    end

    // Length overflow on the MAX_BITS=8 instance: 10-bit frame, then restart
    beat(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 2; i <= 8; i++) beat(1'b1, 1'b1, 1'b0, 1'b0);
    cmp("ovf.err_at_8", int'(if_c.err), 0);
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    cmp("ovf.err_at_9", int'(if_c.err), 1);
    beat(1'b1, 1'b0, 1'b0, 1'b1);
    cmp("ovf.err_at_eof", int'(if_c.err), 1);
    cmp("ovf.done", int'(if_c.frm_done), 1);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    cmp("ovf.err_idle", int'(if_c.err), 1);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    cmp("ovf.err_cleared", int'(if_c.err), 0);

    // Reset mid-frame, then a single-bit frame
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    cmp("rst.rem", int'(if_a.rem), 0);
    cmp("rst.div", int'(if_a.div), 0);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    cmp("rst.no_done", int'(if_a.frm_done), 0);
    beat(1'b1, 1'b1, 1'b1, 1'b1);
    cmp("single.done", int'(if_a.frm_done), 1);
    cmp("single.frm_rem", int'(if_a.frm_rem), 1);
    cmp("single.frm_div", int'(if_a.frm_div), 0);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    cmp("single.pulse_end", int'(if_a.frm_done), 0);

    // Randomized framing, gaps, restarts and occasional resets
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      beat($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
